// File: rtl/ahci_pkg.sv
// Shared definitions for the AHCI data handlers: state encoding, frame limit,
// debug-word field offsets and the byte-length to word-count helper.
package ahci_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_WAIT   = 3'd2,
    S_RDREQ  = 3'd3,
    S_RDDATA = 3'd4,
    S_ACK    = 3'd5,
    S_ERR    = 3'd6
  } dh_state_e;

  localparam logic [13:0] C_MAX_FRM_BYTES = 14'h2000;

  localparam int DBG_STATE_LSB = 0;
  localparam int DBG_ERR_BIT   = 3;
  localparam int DBG_BEAT_LSB  = 8;
  localparam int DBG_WORDS_LSB = 16;

  // Round a byte count up to whole 32-bit words; 0x2000 bytes gives 0x800 words.
  function automatic logic [11:0] len_to_words(input logic [13:0] len);
    return 12'((len + 14'd3) >> 2);
  endfunction

endpackage

// File: rtl/tx_dh_burst_calc.sv
// Burst sizing helper: clamps the remaining word count to the burst limit and
// computes the buffer pointer after a burst of burst_len words.
module tx_dh_burst_calc
  import ahci_pkg::*;
#(
  parameter int C_BURST_WORDS = 32,
  parameter int C_ADDR_WIDTH  = 32
) (
  input  logic [11:0]             words,
  input  logic [8:0]              burst_len,
  input  logic [C_ADDR_WIDTH-1:0] ptr,
  output logic [8:0]              burst,
  output logic [C_ADDR_WIDTH-1:0] ptr_next
);

  localparam logic [11:0] BURST_MAX = 12'(C_BURST_WORDS);

  always_comb begin
    burst    = (words > BURST_MAX) ? 9'(BURST_MAX) : words[8:0];
    ptr_next = ptr + C_ADDR_WIDTH'({burst_len, 2'b00});
  end

endmodule

// File: rtl/tx_dh.sv
// Transmit data handler: fetches frame words from memory in bursts and pushes
// them into the link FIFO. Optional byte swap build: define TX_DH_BSWAP_EN.
module tx_dh
  import ahci_pkg::*;
#(
  parameter int C_BURST_WORDS = 32,
  parameter int C_ADDR_WIDTH  = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    port2dh_load,
  input  logic [C_ADDR_WIDTH-1:0] port2dh_addr,
  input  logic                    tx2dh_req,
  input  logic [13:0]             tx2dh_len,
  output logic                    dh2tx_ack,
  output logic                    dh2tx_err,
  output logic                    dh2mem_req,
  output logic [C_ADDR_WIDTH-1:0] dh2mem_addr,
  output logic [8:0]              dh2mem_len,
  input  logic                    mem2dh_ack,
  input  logic                    mem2dh_valid,
  input  logic [31:0]             mem2dh_data,
  input  logic                    mem2dh_last,
  input  logic                    mem2dh_err,
  input  logic                    txll2dh_afull,
  output logic                    txdma2txll_push,
  output logic [31:0]             txdma2txll_data,
  output logic [31:0]             dh2dbg
);

  dh_state_e               state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [11:0]             words_q, words_d;
  logic [8:0]              burst_q, burst_d;
  logic [7:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;
  logic                    push_q, push_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             beat_word;
  logic [8:0]              burst_calc;
  logic [C_ADDR_WIDTH-1:0] ptr_adv;

  tx_dh_burst_calc #(
    .C_BURST_WORDS(C_BURST_WORDS),
    .C_ADDR_WIDTH (C_ADDR_WIDTH)
  ) u_burst_calc (
    .words    (words_q),
    .burst_len(burst_q),
    .ptr      (ptr_q),
    .burst    (burst_calc),
    .ptr_next (ptr_adv)
  );

`ifdef TX_DH_BSWAP_EN
  assign beat_word = {mem2dh_data[7:0], mem2dh_data[15:8],
                      mem2dh_data[23:16], mem2dh_data[31:24]};
`else
  assign beat_word = mem2dh_data;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    hold_d  = 1'b0;
    push_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (port2dh_load) ptr_d = port2dh_addr;
        // hold_q masks the request level still present right after ack/err
        if (tx2dh_req && !hold_q) begin
          words_d = len_to_words(tx2dh_len);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (words_q == 12'd0) begin
          state_d = S_ACK;
        end else begin
          burst_d = burst_calc;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!txll2dh_afull) state_d = S_RDREQ;
      end
      S_RDREQ: begin
        if (mem2dh_ack) begin
          ptr_d   = ptr_adv;
          words_d = words_q - 12'(burst_q);
          beat_d  = 8'd0;
          state_d = mem2dh_err ? S_ERR : S_RDDATA;
        end
      end
      S_RDDATA: begin
        if (mem2dh_valid) begin
          beat_d = beat_q + 8'd1;
          if (mem2dh_err) begin
            err_d = 1'b1;
          end else if (!err_q) begin
            push_d = 1'b1;
            data_d = beat_word;
          end
          if (mem2dh_last) begin
            if (err_q || mem2dh_err) state_d = S_ERR;
            else if (words_q == 12'd0) state_d = S_ACK;
            else state_d = S_CALC;
          end
        end
      end
      S_ACK: begin
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        hold_d  = 1'b1;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      words_q <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      words_q <= words_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  assign dh2tx_ack       = (state_q == S_ACK);
  assign dh2tx_err       = (state_q == S_ERR);
  assign dh2mem_req      = (state_q == S_RDREQ);
  assign dh2mem_addr     = ptr_q;
  assign dh2mem_len      = burst_q;
  assign txdma2txll_push = push_q;
  assign txdma2txll_data = data_q;

  always_comb begin
    dh2dbg = '0;
    dh2dbg[DBG_STATE_LSB +: 3]  = state_q;
    dh2dbg[DBG_ERR_BIT]         = err_q;
    dh2dbg[DBG_BEAT_LSB +: 8]   = beat_q;
    dh2dbg[DBG_WORDS_LSB +: 12] = words_q;
  end

endmodule
